// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads the instruction memory and
// buffers {pc, instruction} pairs in a small queue drained by decode.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instruction,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]             fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0]  q_instr_q, q_instr_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  q_pc_q, q_pc_d;
  logic                          push, pop;

  assign fetch_pc        = fetch_pc_q;
  assign imem_address    = fetch_pc_q;
  assign out_valid       = (count_q != '0);
  assign out_instruction = q_instr_q[rd_ptr_q];
  assign out_pc          = q_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_instr_d  = q_instr_q;
    q_pc_d     = q_pc_q;

    pop  = out_valid & out_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    push = !redirect_valid && !halt && ((count_q < CNT_W'(DEPTH)) || pop);

    if (push) begin
      q_instr_d[wr_ptr_q] = imem_instruction;
      q_pc_d[wr_ptr_q]    = fetch_pc_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      fetch_pc_d          = fetch_pc_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      q_instr_q  <= '0;
      q_pc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      q_instr_q  <= q_instr_d;
      q_pc_q     <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected deliveries,
// a negedge monitor compares every accepted head against the queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_address;
  logic [15:0] imem_instruction;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_pc;
  logic        out_ready;
  logic [15:0] fetch_pc;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  instr_fetch_unit #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .RESET_PC(16'h0000),
    .DEPTH   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .fetch_pc        (fetch_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: the four words of the streaming test, a fixed pattern elsewhere
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1111;
      16'h0001: mem_word = 16'h2222;
      16'h0002: mem_word = 16'h3333;
      16'h0003: mem_word = 16'h4444;
      default:  mem_word = a ^ 16'hBEEF;
    endcase
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_fetch(input logic [15:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until every queued expectation has been consumed; a stall is a failure.
  task automatic drain(input string name, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 50) begin
      tick();
      cycles++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {out_pc, out_instruction}, 32'hFFFF_FFFF);
      end else begin
        check("delivery", {out_pc, out_instruction}, exp_q.pop_front());
      end
    end
  end

  int cyc;

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    halt = 1'b0; out_ready = 1'b0;

    // Reset for two cycles
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", 32'(out_instruction), 32'd0);
    check("rst_fetch_pc", 32'(fetch_pc), 32'd0);
    check("rst_imem_addr", 32'(imem_address), 32'd0);

    // Streaming fetch
    for (int unsigned i = 0; i < 4; i++) expect_fetch(16'(i));
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stream_valid_before_first_edge", 32'(out_valid), 32'd0);
    drain("stream", cyc);
    check("stream_cycles", 32'(cyc), 32'd5);
    out_ready = 1'b0;

    // Queue fills with PCs 4,5 then redirect to 0x0100
    tick(); tick(); tick();
    check("full_head_pc", 32'(out_pc), 32'h4);
    check("full_fetch_pc", 32'(fetch_pc), 32'h6);
    redirect_valid = 1'b1; redirect_target = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    check("redir_out_valid", 32'(out_valid), 32'd0);
    check("redir_imem_addr", 32'(imem_address), 32'h0100);
    expect_fetch(16'h0100); expect_fetch(16'h0101);
    out_ready = 1'b1;
    drain("redirect", cyc);
    out_ready = 1'b0;

    // Wrap-around from 0xFFFF
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_imem_addr", 32'(imem_address), 32'hFFFF);
    expect_fetch(16'hFFFF); expect_fetch(16'h0000); expect_fetch(16'h0001);
    out_ready = 1'b1;
    drain("wrap", cyc);
    out_ready = 1'b0;

    // Halt with two entries (PCs 2,3) queued
    tick(); tick(); tick();
    check("pre_halt_fetch_pc", 32'(fetch_pc), 32'h4);
    expect_fetch(16'h0002); expect_fetch(16'h0003);
    halt = 1'b1; out_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("halt_fetch_pc", 32'(fetch_pc), 32'h4);
    end
    check("halt_drained_valid", 32'(out_valid), 32'd0);
    check("halt_sb_empty", 32'(exp_q.size()), 32'd0);
    expect_fetch(16'h0004); expect_fetch(16'h0005);
    halt = 1'b0;
    drain("resume", cyc);
    out_ready = 1'b0;

    // Reset with a full queue
    tick(); tick(); tick();
    check("prereset_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pc", 32'(out_pc), 32'd0);
    check("midrst_out_instr", 32'(out_instruction), 32'd0);
    check("midrst_fetch_pc", 32'(fetch_pc), 32'd0);
    check("midrst_imem_addr", 32'(imem_address), 32'd0);

    // Backpressure after release
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    check("bp_head_pc", 32'(out_pc), 32'h0);
    check("bp_fetch_pc", 32'(fetch_pc), 32'h2);
    check("bp_imem_addr", 32'(imem_address), 32'h2);
    for (int unsigned i = 0; i < 4; i++) expect_fetch(16'(i));
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b0;
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch sequencer for the 16-bit instruction memory.
- Owns the program counter and drives the memory address. Captures each returned word with its PC into a small prefetch queue.
- Delivers instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the queue, and a halt input that freezes fetching.

Parameters:
- ADDR_W, 16, address/PC width; memory depth is 2^ADDR_W words.
- DATA_W, 16, instruction width.
- RESET_PC, 16'h0000, PC loaded on reset.
- DEPTH, 2, prefetch queue entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_address  output  ADDR_W  address to instruction memory; equals fetch_pc (combinational).
- imem_instruction  input  DATA_W  combinational read data for imem_address, valid in the same cycle.
- redirect_valid  input  1  load a new PC and flush the queue this cycle.
- redirect_target  input  ADDR_W  new PC when redirect_valid=1.
- halt  input  1  suppress new fetches while high.
- out_valid  output  1  queue head holds a valid instruction.
- out_instruction  output  DATA_W  instruction at queue head.
- out_pc  output  ADDR_W  PC of the head instruction.
- out_ready  input  1  consumer accepts the head this cycle.
- fetch_pc  output  ADDR_W  next PC to be fetched (registered).

Behaviour:
- Reset (reset=1 at an edge):
  - fetch_pc=RESET_PC; queue count=0; read/write pointers=0; all queue storage=0.
  - Outputs: out_valid=0, out_instruction=0, out_pc=0.
  - No push and no pop in a reset cycle; reset overrides every other input.
- out_valid = (count != 0), derived only from registers.
- out_instruction/out_pc = head entry contents. When empty they show the stale head contents, which decode must ignore.
- pop = out_valid & out_ready.
- push = !redirect_valid & !halt & ((count < DEPTH) | pop).
  - A full queue with a simultaneous pop still pushes, giving one instruction per cycle of throughput.
- On push:
  - Entry {fetch_pc, imem_instruction} is written at the write pointer.
  - fetch_pc <= fetch_pc + 1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
- count update: push-only +1; pop-only -1; both or neither unchanged. Pointers wrap modulo DEPTH.
- Latency: a word fetched in cycle N appears at out_* with out_valid=1 in cycle N+1 at the earliest. The first fetch happens in the first cycle after reset deasserts.
- Redirect (redirect_valid=1, reset=0):
  - A pop occurring in the same cycle completes normally; the consumer has taken that word.
  - At the edge: queue flushed (count=0, pointers=0) and fetch_pc <= redirect_target. No push that cycle.
  - Next cycle: out_valid=0 and imem_address=redirect_target. The first target instruction appears one cycle later.
- Halt (halt=1, no redirect):
  - No pushes; fetch_pc holds; the queue keeps draining through pops.
  - Redirect during halt still loads fetch_pc and flushes; fetching resumes from the target when halt falls.
- Priority: reset > redirect > halt > normal fetch.
- No overflow or underflow is possible; pop only when count != 0, push only when a slot is free or being freed.

Test Plan:
- Streaming fetch:
  - Stimulus: mem[0..3]=0x1111,0x2222,0x3333,0x4444; reset 2 cycles, then release with out_ready=1.
  - Required: out_valid rises 1 cycle after release; (out_pc,out_instruction)=(0,0x1111),(1,0x2222),(2,0x3333),(3,0x4444) on consecutive cycles.
- Backpressure:
  - Stimulus: out_ready=0 after release.
  - Required: count reaches 2; fetch_pc and imem_address hold at 2.
  - Stimulus: raise out_ready.
  - Required: PCs 0,1,2,3 delivered in order, no loss or duplicate; out_valid stays 1.
- Redirect flush:
  - Stimulus: queue full holding PCs 4,5; redirect_valid=1, redirect_target=0x0100 for one cycle with out_ready=0.
  - Required: next cycle out_valid=0 and imem_address=0x0100; the following cycle out_pc=0x0100 with mem[0x0100]. PCs 4,5 are never delivered.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF, out_ready=1.
  - Required: out_pc sequence 0xFFFF then 0x0000 then 0x0001.
- Halt:
  - Stimulus: halt=1 for 3 cycles with 2 entries queued and out_ready=1.
  - Required: both entries drain; then out_valid=0; fetch_pc constant throughout.
  - Stimulus: halt=0.
  - Required: fetch resumes at the held fetch_pc.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with a full queue.
  - Required: next cycle out_valid=0, out_pc=0, out_instruction=0, fetch_pc=imem_address=RESET_PC.
